wb_arbiter: RTL and testbench

//  Shares the single Wishbone data port between N core requesters: IF fetch unit (m0) and the
//  MEM-stage LSU/dcache (m1). Round-robin grant per transaction; one transaction in flight.

---
 rtl/wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: N core requesters (0 = IF, 1 = MEM) share one downstream port.
// Latency: request at cycle t -> s_cyc_o at t+1; ack/err routed combinationally to the granted master.
// Backpressure: one transfer in flight; losers hold their request until granted.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN (errors out hung transfers).
module wb_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int GW            = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn_i,
  input  logic [N_MASTERS-1:0]   m_cyc_i,
  input  logic [N_MASTERS-1:0]   m_stb_i,
  input  logic [N_MASTERS-1:0]   m_we_i,
  input  logic [4*N_MASTERS-1:0] m_sel_i,
  input  logic [32*N_MASTERS-1:0] m_adr_i,
  input  logic [32*N_MASTERS-1:0] m_dat_i,
  output logic [31:0]            m_dat_o,
  output logic [N_MASTERS-1:0]   m_ack_o,
  output logic [N_MASTERS-1:0]   m_err_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [3:0]             s_sel_o,
  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  input  logic [31:0]            s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [GW-1:0]          grant_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [N_MASTERS-1:0] req;
  logic                 arb_found;
  logic [GW-1:0]        arb_idx;
  logic                 gnt_cyc;
  logic                 gnt_req;
  logic                 timeout_hit;

  assign req     = m_cyc_i & m_stb_i;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  // Round-robin search: first requester after the last served one, wrapping mod N.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      for (int k = 0; k < N_MASTERS; k++) begin
        if (!arb_found && (k == idx) && req[k]) begin
          arb_found = 1'b1;
          arb_idx   = GW'(k);
        end
      end
    end
  end

  // Forward the granted master's bus fields downstream; held stable by the grant register.
  always_comb begin
    gnt_cyc = 1'b0;
    gnt_req = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (int'(grant_q) == k) begin
        gnt_cyc = m_cyc_i[k];
        gnt_req = req[k];
        s_we_o  = m_we_i[k];
        s_sel_o = m_sel_i[4*k +: 4];
        s_adr_o = m_adr_i[32*k +: 32];
        s_dat_o = m_dat_i[32*k +: 32];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] to_cnt_q;

  // Watchdog: counts BUSY cycles without a response, saturating at the limit.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      to_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      to_cnt_q <= '0;
    end else if (!(s_ack_i || s_err_i) && (to_cnt_q != CW'(TIMEOUT_CYCLES))) begin
      to_cnt_q <= to_cnt_q + CW'(1);
    end
  end

  assign timeout_hit = (state_q == BUSY) && (to_cnt_q == CW'(TIMEOUT_CYCLES));
`else
  // No watchdog: a BUSY transfer ends only on ack, err or abort.
  assign timeout_hit = 1'b0;
`endif

  // Next-state and per-master response routing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    case (state_q)
      IDLE: begin
        // Responses arriving here are dropped: nothing is routed in IDLE.
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Dropping cyc/stb releases the bus in the same cycle; a watchdog hit too.
        s_cyc_o = gnt_req & ~timeout_hit;
        s_stb_o = gnt_req & ~timeout_hit;
        for (int k = 0; k < N_MASTERS; k++) begin
          if (int'(grant_q) == k) begin
            m_ack_o[k] = s_ack_i;
            m_err_o[k] = s_err_i | timeout_hit;
          end
        end
        if (s_ack_i || s_err_i || !gnt_cyc || timeout_hit) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and round-robin pointer; master 0 wins the first arbitration after reset.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with two masters and a scoreboard of expected grants.
// The bench plays the downstream slave and answers each granted transfer.
// Build with WB_ARB_TIMEOUT_EN to exercise the watchdog (limit 8).
module tb_wb_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        rstn_i;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [7:0]  m_sel_i;
  logic [63:0] m_adr_i, m_dat_i;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i, s_err_i;
  logic [0:0]  grant_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          m;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t sb[$];

  wb_arbiter #(.N_MASTERS(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL tb_watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i[k]         = 1'b1;
    m_stb_i[k]         = 1'b1;
    m_we_i[k]          = we;
    m_sel_i[4*k +: 4]  = sel;
    m_adr_i[32*k +: 32] = adr;
    m_dat_i[32*k +: 32] = dat;
  endtask

  task automatic clr_req(input int k);
    m_cyc_i[k] = 1'b0;
    m_stb_i[k] = 1'b0;
    m_we_i[k]  = 1'b0;
  endtask

  task automatic push(input int k, input logic we, input logic [3:0] sel,
                      input logic [31:0] adr, input logic [31:0] dat);
    txn_t t;
    t.m = k; t.we = we; t.sel = sel; t.adr = adr; t.dat = dat;
    sb.push_back(t);
  endtask

  task automatic do_reset();
    rstn_i  = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    sb.delete();
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
  endtask

  // Wait for the next granted transfer, compare it against the scoreboard head,
  // ack it with rdat, then check the mandatory idle cycle.
  task automatic serve(input string tag, input logic [31:0] rdat, input bit drop);
    txn_t t;
    int   w;
    w = 0;
    while (s_cyc_o !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_cyc"}, 64'(s_cyc_o), 64'd1);
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      t = sb.pop_front();
      chk({tag, "_grant"}, 64'(grant_o), 64'(t.m));
      chk({tag, "_stb"},   64'(s_stb_o), 64'd1);
      chk({tag, "_adr"},   64'(s_adr_o), 64'(t.adr));
      chk({tag, "_we"},    64'(s_we_o),  64'(t.we));
      chk({tag, "_sel"},   64'(s_sel_o), 64'(t.sel));
      if (t.we) chk({tag, "_wdat"}, 64'(s_dat_o), 64'(t.dat));
      s_ack_i = 1'b1;
      s_dat_i = rdat;
      #1;
      chk({tag, "_ack"},  64'(m_ack_o), (t.m == 1) ? 64'd2 : 64'd1);
      chk({tag, "_rdat"}, 64'(m_dat_o), 64'(rdat));
      chk({tag, "_noerr"}, 64'(m_err_o), 64'd0);
      tick();
      s_ack_i = 1'b0;
      s_dat_i = '0;
      if (drop) clr_req(t.m);
      #1;
      chk({tag, "_idle_cyc"}, 64'(s_cyc_o), 64'd0);
      chk({tag, "_idle_ack"}, 64'(m_ack_o), 64'd0);
    end
  endtask

  initial begin
    int bad;

    // Reset values, with a stray ack on the slave side that must not leak through.
    rstn_i  = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    s_dat_i = '0; s_ack_i = 1'b1; s_err_i = 1'b1;
    #3;
    chk("rst_cyc",   64'(s_cyc_o), 64'd0);
    chk("rst_stb",   64'(s_stb_o), 64'd0);
    chk("rst_ack",   64'(m_ack_o), 64'd0);
    chk("rst_err",   64'(m_err_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    do_reset();

    // 1: single read from m1, one-cycle arbitration latency.
    set_req(1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    push(1, 1'b0, 4'hF, 32'h0000_0100, 32'h0);
    #1;
    chk("t1_lat0", 64'(s_cyc_o), 64'd0);
    tick();
    chk("t1_lat1", 64'(s_cyc_o), 64'd1);
    serve("t1", 32'hDEAD_BEEF, 1'b1);
    chk("t1_grant_hold", 64'(grant_o), 64'd1);

    // 2: both masters request from reset and keep requesting: 0,1,0,1.
    do_reset();
    set_req(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
    set_req(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
    push(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
    push(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
    push(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
    push(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
    tick();
    serve("t2a", 32'h1111_0000, 1'b0);
    serve("t2b", 32'h2222_0000, 1'b0);
    serve("t2c", 32'h3333_0000, 1'b0);
    serve("t2d", 32'h4444_0000, 1'b1);
    clr_req(0);
    tick();
    chk("t2_quiet", 64'(s_cyc_o), 64'd0);

    // 3: m1 write arrives while m0 is BUSY; downstream stays on m0 until acked.
    set_req(0, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
    push(0, 1'b0, 4'hF, 32'h0000_0300, 32'h0);
    tick();
    set_req(1, 1'b1, 4'b0011, 32'h0000_0400, 32'h0000_1234);
    push(1, 1'b1, 4'b0011, 32'h0000_0400, 32'h0000_1234);
    #1;
    chk("t3_hold_we",  64'(s_we_o),  64'd0);
    chk("t3_hold_adr", 64'(s_adr_o), 64'h300);
    serve("t3a", 32'hCAFE_0001, 1'b1);
    serve("t3b", 32'h0, 1'b1);

    // 4: slave error on an m0 read.
    set_req(0, 1'b0, 4'hF, 32'h0000_0500, 32'h0);
    tick();
    chk("t4_busy", 64'(s_cyc_o), 64'd1);
    s_err_i = 1'b1;
    #1;
    chk("t4_err", 64'(m_err_o), 64'd1);
    chk("t4_ack", 64'(m_ack_o), 64'd0);
    tick();
    s_err_i = 1'b0;
    #1;
    chk("t4_idle_cyc", 64'(s_cyc_o), 64'd0);
    chk("t4_err_once", 64'(m_err_o), 64'd0);
    tick();
    chk("t4_rearb", 64'(s_cyc_o), 64'd1);
    clr_req(0);
    #1;
    chk("t4_release", 64'(s_cyc_o), 64'd0);
    tick();

    // 5: m0 aborts mid-transfer; a late ack is dropped.
    set_req(0, 1'b0, 4'hF, 32'h0000_0600, 32'h0);
    tick();
    chk("t5_busy", 64'(s_cyc_o), 64'd1);
    clr_req(0);
    #1;
    chk("t5_abort_cyc", 64'(s_cyc_o), 64'd0);
    tick();
    s_ack_i = 1'b1;
    #1;
    chk("t5_late_ack", 64'(m_ack_o), 64'd0);
    tick();
    s_ack_i = 1'b0;

    // 6: slave never answers.
    set_req(0, 1'b0, 4'hF, 32'h0000_0700, 32'h0);
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("t6_wait_err", 64'(m_err_o), 64'd0);
      chk("t6_wait_cyc", 64'(s_cyc_o), 64'd1);
      tick();
    end
    chk("t6_to_err", 64'(m_err_o), 64'd1);
    chk("t6_to_cyc", 64'(s_cyc_o), 64'd0);
    tick();
    chk("t6_to_once", 64'(m_err_o), 64'd0);
    chk("t6_to_idle", 64'(s_cyc_o), 64'd0);
    clr_req(0);
`else
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      if (s_cyc_o !== 1'b1 || m_err_o !== 2'b00) bad++;
      tick();
    end
    chk("t6_no_timeout", 64'(bad), 64'd0);
    clr_req(0);
    #1;
    chk("t6_release", 64'(s_cyc_o), 64'd0);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
